seg_symbol_reader: RTL and testbench
====================================

// Module: seg_symbol_reader
// PURPOSE
//  Inverse of the 7-segment symbol encoder. Samples an 8-bit segment bus and waits for the pattern to hold steady.
//  Decodes each new stable pattern back to its 6-bit symbol code (0..41) and queues the codes in a small FIFO with a
//  valid/ready read port. Used to loop back and self-check display drivers and to read a panel through the SWI header.
// PARAMETERS
//  STABLE_CYCLES  4   consecutive identical samples required before a pattern counts as stable (>=2)
//  FIFO_DEPTH     4   symbol queue depth (power of 2, >=2)
//  NBITS_SEG      8   segment bus width; bit7 = dp, bits6:0 = g..a
// PORTS
//  clk_2      in   1        system clock
//  reset_n    in   1        synchronous reset, active low
//  seg_in     in   8        segment pattern under observation (sampled each clk_2 edge)
//  sym_code   out  6        head-of-FIFO symbol code
//  sym_err    out  1        head entry was an unknown pattern (sym_code = 63)
//  sym_dp     out  1        head entry dp bit (only with SEG_READER_DP_EN; else tied 0)
//  sym_valid  out  1        FIFO not empty
//  sym_ready  in   1        consumer accepts head when sym_valid & sym_ready
//  overflow   out  1        sticky: a stable symbol was dropped because the FIFO was full
//  fill       out  3        current FIFO occupancy 0..FIFO_DEPTH
// BEHAVIOUR
//  Reset (reset_n=0 at edge): FSM->IDLE, counter=0, FIFO empty, sym_valid=0, sym_code=0, sym_err=0, sym_dp=0,
//   overflow=0, fill=0. Reset asserted mid-count or mid-read discards everything.
//  Input registered once (seg_q); comparisons use seg_q vs previous sample seg_p (full 8 bits).
//  FSM:
//   IDLE : seg_q!=seg_p -> COUNT (cnt=1). Else stay.
//   COUNT: seg_q!=seg_p -> cnt=1 (restart). Else cnt++; on cnt==STABLE_CYCLES-1 -> HELD and emit.
//          Stable pattern with bits6:0==0 (blank) -> HELD with no emit.
//   HELD : wait; seg_q!=seg_p -> COUNT (cnt=1). The same symbol repeats only after a different stable
//          pattern (blank included) intervenes.
//  Latency: emitted entry visible on sym_valid 1 cycle after the qualifying edge.
//   First emit is STABLE_CYCLES+2 edges after seg_in changes.
//  Decode (bits6:0; on an alias the lowest code wins):
//   3f->0 06->1 5b->2 4f->3 66->4 6d->5 7d->6 07->7 7f->8 6f->9 77->10 7c->11 39->12 5e->13 79->14 71->15
//   58->19 76->24 74->25 10->26 1e->28 38->29 54->30 5c->32 73->33 67->34 50->35 78->37 3e->38 1c->39
//   6e->40 63->41. Any other non-blank pattern -> code 63, sym_err=1.
//  FIFO: write on emit, pop on sym_valid&sym_ready.
//   Same-cycle push+pop when full succeeds: no overflow, fill unchanged.
//   Push when full with no pop: entry dropped, overflow set until reset.
//   Pop when empty is ignored. Pointers wrap modulo FIFO_DEPTH.
//   sym_code/sym_err/sym_dp are stable while sym_valid=1 and sym_ready=0.
// CONFIGURATION
//  SEG_READER_DP_EN defined: bit7 is carried into the FIFO as sym_dp; decode ignores bit7.
//  Not defined: bit7=1 on a stable non-blank pattern decodes as unknown (63, sym_err=1); sym_dp tied 0.
//   Bit7 still takes part in the stability compare in both builds.
// STRUCTURE
//  Shared package seg7_pkg: symbol code constants (ZERO..GRAU, SYM_UNKNOWN=6'd63) and the pattern constants
//   used by the encoder; state_t enum {IDLE,COUNT,HELD}; decode function seg_to_sym(logic[6:0]).
//  One sub-module: seg_sym_fifo (parameterised sync FIFO, same clk_2/reset_n).
//   Stability FSM and decode stay in the top.
// TESTING
//  1 Reset: hold reset_n=0 three cycles with seg_in=8'h3f -> sym_valid=0, fill=0, overflow=0.
//  2 seg_in 00->5b held 6 cycles, sym_ready=1 -> exactly one entry, code 2, err 0; no repeat while held.
//  3 Glitch: 7f for 2 cycles then 66 held (STABLE_CYCLES=4) -> only code 4 queued; 7f never emitted.
//  4 Sequence 3f,00,3f,6d,42, each held 5 cycles, sym_ready=0 -> FIFO holds 0,0,5,63(err);
//    a fifth symbol 06 sets overflow and fill stays 4.
//  5 With FIFO full, raise sym_ready on the emit cycle of a new symbol -> no overflow, fill stays 4, new code at tail.
//  6 SEG_READER_DP_EN: seg_in=8'hbf stable -> code 0, sym_dp=1; without macro -> code 63, sym_err=1.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: symbol codes, segment patterns (bit6..0 = g..a),
// reader FSM states, FIFO entry layout and the pattern-to-symbol decoder.
package seg7_pkg;

   localparam logic [5:0] ZERO = 6'd0, ONE = 6'd1, TWO = 6'd2, THREE = 6'd3, FOUR = 6'd4,
                          FIVE = 6'd5, SIX = 6'd6, SEVEN = 6'd7, EIGHT = 6'd8, NINE = 6'd9;
   localparam logic [5:0] CHR_A = 6'd10, CHR_B = 6'd11, CHR_C = 6'd12, CHR_D = 6'd13,
                          CHR_E = 6'd14, CHR_F = 6'd15, CHR_C_LO = 6'd19, CHR_H = 6'd24,
                          CHR_H_LO = 6'd25, CHR_I_LO = 6'd26, CHR_J = 6'd28, CHR_L = 6'd29,
                          CHR_N_LO = 6'd30, CHR_O_LO = 6'd32, CHR_P = 6'd33, CHR_Q_LO = 6'd34,
                          CHR_R_LO = 6'd35, CHR_T_LO = 6'd37, CHR_U = 6'd38, CHR_U_LO = 6'd39,
                          CHR_Y_LO = 6'd40, GRAU = 6'd41;
   localparam logic [5:0] SYM_UNKNOWN = 6'd63;

   localparam logic [6:0] PAT_ZERO = 7'h3f, PAT_ONE = 7'h06, PAT_TWO = 7'h5b, PAT_THREE = 7'h4f,
                          PAT_FOUR = 7'h66, PAT_FIVE = 7'h6d, PAT_SIX = 7'h7d, PAT_SEVEN = 7'h07,
                          PAT_EIGHT = 7'h7f, PAT_NINE = 7'h6f;
   localparam logic [6:0] PAT_A = 7'h77, PAT_B = 7'h7c, PAT_C = 7'h39, PAT_D = 7'h5e,
                          PAT_E = 7'h79, PAT_F = 7'h71, PAT_C_LO = 7'h58, PAT_H = 7'h76,
                          PAT_H_LO = 7'h74, PAT_I_LO = 7'h10, PAT_J = 7'h1e, PAT_L = 7'h38,
                          PAT_N_LO = 7'h54, PAT_O_LO = 7'h5c, PAT_P = 7'h73, PAT_Q_LO = 7'h67,
                          PAT_R_LO = 7'h50, PAT_T_LO = 7'h78, PAT_U = 7'h3e, PAT_U_LO = 7'h1c,
                          PAT_Y_LO = 7'h6e, PAT_GRAU = 7'h63;

   typedef enum logic [1:0] {IDLE, COUNT, HELD} state_t;

   typedef struct packed {
      logic [5:0] code;
      logic       err;
      logic       dp;
   } sym_entry_t;

   function automatic logic [5:0] seg_to_sym(logic [6:0] seg);
      logic [5:0] code;
      code = SYM_UNKNOWN;
      case (seg)
         PAT_ZERO:  code = ZERO;      PAT_ONE:   code = ONE;      PAT_TWO:   code = TWO;
         PAT_THREE: code = THREE;     PAT_FOUR:  code = FOUR;     PAT_FIVE:  code = FIVE;
         PAT_SIX:   code = SIX;       PAT_SEVEN: code = SEVEN;    PAT_EIGHT: code = EIGHT;
         PAT_NINE:  code = NINE;      PAT_A:     code = CHR_A;    PAT_B:     code = CHR_B;
         PAT_C:     code = CHR_C;     PAT_D:     code = CHR_D;    PAT_E:     code = CHR_E;
         PAT_F:     code = CHR_F;     PAT_C_LO:  code = CHR_C_LO; PAT_H:     code = CHR_H;
         PAT_H_LO:  code = CHR_H_LO;  PAT_I_LO:  code = CHR_I_LO; PAT_J:     code = CHR_J;
         PAT_L:     code = CHR_L;     PAT_N_LO:  code = CHR_N_LO; PAT_O_LO:  code = CHR_O_LO;
         PAT_P:     code = CHR_P;     PAT_Q_LO:  code = CHR_Q_LO; PAT_R_LO:  code = CHR_R_LO;
         PAT_T_LO:  code = CHR_T_LO;  PAT_U:     code = CHR_U;    PAT_U_LO:  code = CHR_U_LO;
         PAT_Y_LO:  code = CHR_Y_LO;  PAT_GRAU:  code = GRAU;
         default:   code = SYM_UNKNOWN;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/seg_sym_fifo.sv
// Synchronous symbol FIFO with sticky overflow; a push into a full FIFO is
// accepted when a pop happens on the same edge.
module seg_sym_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                           clk_2,
   input  logic                           reset_n,
   input  logic                           push,
   input  logic [WIDTH-1:0]               push_data,
   input  logic                           pop_req,
   output logic [WIDTH-1:0]               head,
   output logic                           valid,
   output logic [$clog2(DEPTH+1)-1:0]     fill,
   output logic                           overflow
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr, wr_ptr;
   logic [CW-1:0]    count;
   logic             do_pop, do_push;

   always_comb begin
      do_pop  = pop_req && (count != '0);
      do_push = push && ((count != CW'(DEPTH)) || do_pop);
   end

   always_ff @(posedge clk_2) begin
      if (!reset_n) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (do_pop && !do_push) count <= count - CW'(1);
         if (push && !do_push) overflow <= 1'b1;
      end
   end

   always_comb begin
      valid = (count != '0);
      head  = valid ? mem[rd_ptr] : '0;
      fill  = count;
   end

endmodule

// File: rtl/seg_symbol_reader.sv
// Reads a 7-segment bus back into symbol codes once a pattern holds steady.
// Build option SEG_READER_DP_EN carries the dp bit into the queue instead of flagging it unknown.
module seg_symbol_reader
   import seg7_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned FIFO_DEPTH    = 4,
   parameter int unsigned NBITS_SEG     = 8
) (
   input  logic                               clk_2,
   input  logic                               reset_n,
   input  logic [NBITS_SEG-1:0]               seg_in,
   output logic [5:0]                         sym_code,
   output logic                               sym_err,
   output logic                               sym_dp,
   output logic                               sym_valid,
   input  logic                               sym_ready,
   output logic                               overflow,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fill
);
   localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);

   state_t               state;
   logic [CNT_W-1:0]     cnt;
   logic [NBITS_SEG-1:0] seg_q, seg_p, last_stable;
   logic                 push;
   logic [5:0]           dec_code;
   sym_entry_t           push_data, new_entry, head;

   always_comb begin
      dec_code = seg_to_sym(seg_q[6:0]);
`ifdef SEG_READER_DP_EN
      new_entry.dp = seg_q[NBITS_SEG-1];
`else
      new_entry.dp = 1'b0;
      if (seg_q[NBITS_SEG-1]) dec_code = SYM_UNKNOWN;
`endif
      new_entry.code = dec_code;
      new_entry.err  = (dec_code == SYM_UNKNOWN);
   end

   // last_stable suppresses re-emitting a pattern after a glitch that never became stable
   always_ff @(posedge clk_2) begin
      if (!reset_n) begin
         state       <= IDLE;
         cnt         <= '0;
         seg_q       <= '0;
         seg_p       <= '0;
         last_stable <= '0;
         push        <= 1'b0;
         push_data   <= '0;
      end else begin
         seg_q <= seg_in;
         seg_p <= seg_q;
         push  <= 1'b0;
         unique case (state)
            IDLE, HELD: begin
               if (seg_q != seg_p) begin
                  state <= COUNT;
                  cnt   <= CNT_W'(1);
               end
            end
            COUNT: begin
               if (seg_q != seg_p) begin
                  cnt <= CNT_W'(1);
               end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                  state       <= HELD;
                  cnt         <= '0;
                  last_stable <= seg_q;
                  if (seg_q[6:0] != '0 && seg_q != last_stable) begin
                     push      <= 1'b1;
                     push_data <= new_entry;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   seg_sym_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(sym_entry_t))
   ) u_fifo (
      .clk_2     (clk_2),
      .reset_n   (reset_n),
      .push      (push),
      .push_data (push_data),
      .pop_req   (sym_ready),
      .head      (head),
      .valid     (sym_valid),
      .fill      (fill),
      .overflow  (overflow)
   );

   always_comb begin
      sym_code = head.code;
      sym_err  = head.err;
      sym_dp   = head.dp;
   end

endmodule

// File: tb/tb_seg_symbol_reader.sv
// Self-checking bench for seg_symbol_reader: run-length symbol model plus directed scenarios.
// Expectations follow SEG_READER_DP_EN the same way the design does.
module tb_seg_symbol_reader;
   localparam int STABLE = 4;
   localparam int DEPTH  = 4;

   logic       clk_2 = 1'b0;
   logic       reset_n;
   logic [7:0] seg_in;
   logic [5:0] sym_code;
   logic       sym_err, sym_dp, sym_valid, sym_ready, overflow;
   logic [2:0] fill;

   seg_symbol_reader #(
      .STABLE_CYCLES (STABLE),
      .FIFO_DEPTH    (DEPTH),
      .NBITS_SEG     (8)
   ) dut (
      .clk_2     (clk_2),
      .reset_n   (reset_n),
      .seg_in    (seg_in),
      .sym_code  (sym_code),
      .sym_err   (sym_err),
      .sym_dp    (sym_dp),
      .sym_valid (sym_valid),
      .sym_ready (sym_ready),
      .overflow  (overflow),
      .fill      (fill)
   );

   always #5 clk_2 = ~clk_2;

   typedef struct {
      int code;
      bit err;
      bit dp;
   } ent_t;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   pat_tab[42];
   ent_t mq[$];
   ent_t log_q[$];
   bit   m_ovf;
   logic [7:0] run_val, last_stable;
   int   run_len;
   bit   pipe_v[2];
   ent_t pipe_e[2];
   bit   done = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic ent_t model_decode(input logic [7:0] p);
      ent_t e;
      bit   found = 0;
      e.code = 63; e.err = 1; e.dp = 0;
`ifdef SEG_READER_DP_EN
      e.dp = p[7];
      for (int i = 0; i < 42; i++)
         if (!found && pat_tab[i] == int'(p[6:0])) begin e.code = i; e.err = 0; found = 1; end
`else
      if (!p[7])
         for (int i = 0; i < 42; i++)
            if (!found && pat_tab[i] == int'(p[6:0])) begin e.code = i; e.err = 0; found = 1; end
`endif
      return e;
   endfunction

   // Model: a run of STABLE identical samples of a new pattern queues its symbol two edges later.
   always @(posedge clk_2) begin
      if (!reset_n) begin
         mq.delete();
         m_ovf = 0; run_val = 8'h00; last_stable = 8'h00; run_len = STABLE;
         pipe_v[0] = 0; pipe_v[1] = 0;
      end else begin
         if (mq.size() > 0 && sym_ready) log_q.push_back(mq.pop_front());
         if (pipe_v[1]) begin
            if (mq.size() < DEPTH) mq.push_back(pipe_e[1]);
            else m_ovf = 1;
         end
         pipe_v[1] = pipe_v[0]; pipe_e[1] = pipe_e[0]; pipe_v[0] = 0;
         if (seg_in == run_val) begin
            if (run_len < 1000) run_len++;
         end else begin
            run_val = seg_in; run_len = 1;
         end
         if (run_len == STABLE && run_val != last_stable) begin
            last_stable = run_val;
            if (run_val[6:0] != 7'h00) begin
               pipe_v[0] = 1;
               pipe_e[0] = model_decode(run_val);
            end
         end
      end
   end

   always @(negedge clk_2) begin
      if (reset_n === 1'b1 && !done) begin
         check("valid", int'(sym_valid), int'(mq.size() > 0));
         check("fill", int'(fill), mq.size());
         check("overflow", int'(overflow), int'(m_ovf));
         if (mq.size() > 0) begin
            check("code", int'(sym_code), mq[0].code);
            check("err", int'(sym_err), int'(mq[0].err));
            check("dp", int'(sym_dp), int'(mq[0].dp));
         end
      end
   end

   task automatic drive(input logic [7:0] v, input int n);
      seg_in = v;
      repeat (n) @(negedge clk_2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      foreach (pat_tab[i]) pat_tab[i] = -1;
      pat_tab[0] = 'h3f;  pat_tab[1] = 'h06;  pat_tab[2] = 'h5b;  pat_tab[3] = 'h4f;
      pat_tab[4] = 'h66;  pat_tab[5] = 'h6d;  pat_tab[6] = 'h7d;  pat_tab[7] = 'h07;
      pat_tab[8] = 'h7f;  pat_tab[9] = 'h6f;  pat_tab[10] = 'h77; pat_tab[11] = 'h7c;
      pat_tab[12] = 'h39; pat_tab[13] = 'h5e; pat_tab[14] = 'h79; pat_tab[15] = 'h71;
      pat_tab[19] = 'h58; pat_tab[24] = 'h76; pat_tab[25] = 'h74; pat_tab[26] = 'h10;
      pat_tab[28] = 'h1e; pat_tab[29] = 'h38; pat_tab[30] = 'h54; pat_tab[32] = 'h5c;
      pat_tab[33] = 'h73; pat_tab[34] = 'h67; pat_tab[35] = 'h50; pat_tab[37] = 'h78;
      pat_tab[38] = 'h3e; pat_tab[39] = 'h1c; pat_tab[40] = 'h6e; pat_tab[41] = 'h63;

      // reset held three cycles with a live pattern on the bus
      reset_n = 1'b0; seg_in = 8'h3f; sym_ready = 1'b0;
      repeat (3) @(negedge clk_2);
      check("rst_valid", int'(sym_valid), 0);
      check("rst_fill", int'(fill), 0);
      check("rst_overflow", int'(overflow), 0);
      seg_in = 8'h00;
      @(negedge clk_2);
      reset_n = 1'b1;

      // single stable symbol, no repeat while held or after a short glitch
      sym_ready = 1'b1;
      log_q.delete();
      drive(8'h5b, 12);
      check("t2_count_held", log_q.size(), 1);
      drive(8'h7f, 2);
      drive(8'h5b, 10);
      check("t2_count", log_q.size(), 1);
      if (log_q.size() > 0) begin
         check("t2_code", log_q[0].code, 2);
         check("t2_err", int'(log_q[0].err), 0);
      end

      // glitch shorter than the stability window
      log_q.delete();
      drive(8'h7f, 2);
      drive(8'h66, 10);
      check("t3_count", log_q.size(), 1);
      if (log_q.size() > 0) check("t3_code", log_q[0].code, 4);

      // fill the queue, blank separating two identical symbols, then overflow
      sym_ready = 1'b0;
      drive(8'h3f, 5); drive(8'h00, 5); drive(8'h3f, 5); drive(8'h6d, 5); drive(8'h42, 5);
      repeat (3) @(negedge clk_2);
      check("t4_fill", int'(fill), 4);
      check("t4_overflow", int'(overflow), 0);
      check("t4_head", int'(sym_code), 0);
      check("t4_mq_size", mq.size(), 4);
      if (mq.size() == 4) begin
         check("t4_q1", mq[1].code, 0);
         check("t4_q2", mq[2].code, 5);
         check("t4_q3", mq[3].code, 63);
         check("t4_q3_err", int'(mq[3].err), 1);
      end
      drive(8'h06, 5);
      repeat (3) @(negedge clk_2);
      check("t4_ovf_set", int'(overflow), 1);
      check("t4_ovf_fill", int'(fill), 4);

      // full queue, pop on the push edge keeps the new symbol
      reset_n = 1'b0;
      drive(8'h00, 2);
      reset_n = 1'b1;
      check("t5_ovf_cleared", int'(overflow), 0);
      drive(8'h06, 5); drive(8'h5b, 5); drive(8'h4f, 5); drive(8'h66, 5);
      repeat (3) @(negedge clk_2);
      check("t5_full", int'(fill), 4);
      log_q.delete();
      seg_in = 8'h6d;
      repeat (5) @(negedge clk_2);
      sym_ready = 1'b1;
      @(negedge clk_2);
      sym_ready = 1'b0;
      check("t5_overflow", int'(overflow), 0);
      check("t5_fill", int'(fill), 4);
      check("t5_head", int'(sym_code), 2);
      check("t5_popped", log_q.size(), 1);
      if (log_q.size() > 0) check("t5_popped_code", log_q[0].code, 1);
      repeat (3) @(negedge clk_2);
      check("t5_fill_hold", int'(fill), 4);
      log_q.delete();
      sym_ready = 1'b1;
      repeat (6) @(negedge clk_2);
      check("t5_drained", int'(fill), 0);
      check("t5_drain_count", log_q.size(), 4);
      if (log_q.size() == 4) begin
         check("t5_d0", log_q[0].code, 2);
         check("t5_d1", log_q[1].code, 3);
         check("t5_d2", log_q[2].code, 4);
         check("t5_tail", log_q[3].code, 5);
      end

      // dp bit handling, dp-only pattern is blank
      log_q.delete();
      drive(8'hbf, 10);
      check("t6_count", log_q.size(), 1);
      if (log_q.size() > 0) begin
`ifdef SEG_READER_DP_EN
         check("t6_code", log_q[0].code, 0);
         check("t6_err", int'(log_q[0].err), 0);
         check("t6_dp", int'(log_q[0].dp), 1);
`else
         check("t6_code", log_q[0].code, 63);
         check("t6_err", int'(log_q[0].err), 1);
         check("t6_dp", int'(log_q[0].dp), 0);
`endif
      end
      drive(8'h80, 10);
      check("t6_blank", log_q.size(), 1);
      drive(8'hbf, 10);
      check("t6_after_blank", log_q.size(), 2);

      done = 1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
